// File: rtl/raster_scheduler_if.sv
// Port bundle between the raster scheduler and its environment (object source,
// rasterizer bank, framebuffer), plus debug visibility of FSM state and errors.
interface raster_scheduler_if #(
  parameter int N_RAST = 16,
  parameter int OBJ_W  = 32,
  parameter int PIX_W  = 24
);
  // Handshakes: a transfer happens on a rising clock edge where valid and ready
  // are both 1. The source holds data stable while valid=1 and ready=0. The
  // rasterizer side uses a rising edge of rast_data_write as its "valid".
  logic [OBJ_W-1:0]        obj_in;
  logic                    obj_valid;
  logic                    obj_ready;
  logic [OBJ_W-1:0]        current_task;
  logic                    next_task;
  logic [N_RAST-1:0]       rast_task_complete;
  logic [N_RAST*PIX_W-1:0] rast_data;
  logic [N_RAST-1:0]       rast_data_write;
  logic [N_RAST-1:0]       rast_output_written;
  logic [PIX_W-1:0]        fb_data;
  logic                    fb_valid;
  logic                    fb_ready;
  logic                    obj_done;
  logic [15:0]             obj_count;
  logic [1:0]              state_dbg;
  logic                    err_overrun;

  modport master (
    output obj_in, obj_valid, rast_task_complete, rast_data, rast_data_write, fb_ready,
    input  obj_ready, current_task, next_task, rast_output_written, fb_data, fb_valid,
           obj_done, obj_count, state_dbg, err_overrun
  );

  modport slave (
    input  obj_in, obj_valid, rast_task_complete, rast_data, rast_data_write, fb_ready,
    output obj_ready, current_task, next_task, rast_output_written, fb_data, fb_valid,
           obj_done, obj_count, state_dbg, err_overrun
  );
endinterface

// File: rtl/raster_scheduler.sv
// Broadcasts one object to a bank of rasterizers, merges their pixel writes
// round-robin into a single framebuffer stream, and reports object completion.
module raster_scheduler #(
  parameter int N_RAST       = 16,
  parameter int GUARD_CYCLES = 2,
  parameter int OBJ_W        = 32,
  parameter int PIX_W        = 24
) (
  input logic clock,
  input logic reset,
  raster_scheduler_if.slave bus
);
  localparam int RR_W = $clog2(N_RAST);

  typedef logic [OBJ_W-1:0] object_t;
  typedef logic [PIX_W-1:0] pixel_info_t;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, GUARD = 2'd2, RUN = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [2:0]        guard_cnt, guard_cnt_nxt;
  logic              latch_obj, done_set;
  object_t           current_task;
  logic [N_RAST-1:0] slot_full, wr_q, rise;
  pixel_info_t       slot_data [N_RAST];
  logic [RR_W-1:0]   rr_ptr, grant_idx, idx_sel;
  logic              grant_vld, can_load, do_grant, drain_done;
  logic              fb_valid_q, obj_done_q, err_q;
  pixel_info_t       fb_data_q;
  logic [15:0]       obj_count_q;
  int                idx;

  assign rise       = bus.rast_data_write & ~wr_q;
  assign can_load   = !fb_valid_q || bus.fb_ready;
  assign do_grant   = can_load && grant_vld;
  // Completion needs every rasterizer done and nothing left anywhere in the pipe.
  assign drain_done = (&bus.rast_task_complete) && (slot_full == '0) &&
                      (rise == '0) && !fb_valid_q;

  always_comb begin
    state_nxt     = state;
    guard_cnt_nxt = guard_cnt;
    latch_obj     = 1'b0;
    done_set      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.obj_valid) begin
          latch_obj = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        guard_cnt_nxt = 3'd0;
        state_nxt     = GUARD;
      end
      GUARD: begin
        if (guard_cnt == 3'(GUARD_CYCLES - 1)) state_nxt = RUN;
        else guard_cnt_nxt = guard_cnt + 3'd1;
      end
      RUN: begin
        if (drain_done) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round-robin search starting just after the last granted slot.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_sel   = '0;
    for (int k = 1; k <= N_RAST; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_RAST) idx = idx - N_RAST;
      idx_sel = RR_W'(idx);
      if (!grant_vld && slot_full[idx_sel]) begin
        grant_vld = 1'b1;
        grant_idx = idx_sel;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      guard_cnt    <= 3'd0;
      current_task <= '0;
      obj_done_q   <= 1'b0;
      obj_count_q  <= 16'd0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_cnt_nxt;
      obj_done_q <= done_set;
      if (latch_obj) current_task <= bus.obj_in;
      if (done_set) obj_count_q <= obj_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_full  <= '0;
      wr_q       <= '0;
      rr_ptr     <= RR_W'(N_RAST - 1);
      fb_valid_q <= 1'b0;
      fb_data_q  <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < N_RAST; i++) slot_data[i] <= '0;
    end else begin
      wr_q <= bus.rast_data_write;
      for (int i = 0; i < N_RAST; i++) begin
        if (rise[i]) begin
          if (slot_full[i]) begin
            err_q <= 1'b1;
          end else begin
            slot_full[i] <= 1'b1;
            slot_data[i] <= bus.rast_data[i*PIX_W +: PIX_W];
          end
        end
      end
      // A grant only ever clears a full slot, so it never collides with a capture.
      if (do_grant) begin
        slot_full[grant_idx] <= 1'b0;
        fb_data_q            <= slot_data[grant_idx];
        fb_valid_q           <= 1'b1;
        rr_ptr               <= grant_idx;
      end else if (bus.fb_ready) begin
        fb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.obj_ready           = (state == IDLE);
  assign bus.next_task           = (state == START);
  assign bus.current_task        = current_task;
  assign bus.rast_output_written = ~slot_full;
  assign bus.fb_data             = fb_data_q;
  assign bus.fb_valid            = fb_valid_q;
  assign bus.obj_done            = obj_done_q;
  assign bus.obj_count           = obj_count_q;
  assign bus.state_dbg           = state;
  assign bus.err_overrun         = err_q;
endmodule

// File: tb/tb_raster_scheduler.sv
// Directed bench for raster_scheduler with four rasterizers: a per-cycle vector
// table for one full object plus sequences for overrun and mid-run reset.
module tb_raster_scheduler;
  localparam int N = 4;
  localparam int PW = 24;
  localparam logic [31:0] O1 = 32'hCAFE_0001;
  localparam logic [31:0] O2 = 32'hBEEF_0002;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  raster_scheduler_if #(.N_RAST(N), .OBJ_W(32), .PIX_W(PW)) bus ();

  raster_scheduler #(.N_RAST(N), .GUARD_CYCLES(2), .OBJ_W(32), .PIX_W(PW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ov;
    logic [31:0] oin;
    logic [3:0]  tc;
    logic [3:0]  rdw;
    logic [7:0]  tag;
    logic        rdy;
    logic        e_ordy;
    logic        e_nt;
    logic        e_fv;
    logic [23:0] e_fd;
    logic [3:0]  e_row;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ov, input logic [31:0] oin, input logic [3:0] tc,
                       input logic [3:0] rdw, input logic [7:0] tag, input logic rdy);
    bus.obj_valid          = ov;
    bus.obj_in             = oin;
    bus.rast_task_complete = tc;
    bus.rast_data_write    = rdw;
    bus.fb_ready           = rdy;
    for (int i = 0; i < N; i++) bus.rast_data[i*PW +: PW] = {tag, 12'h000, 4'(i)};
  endtask

  initial begin
    //             ov  oin tc    rdw   tag    rdy  ordy nt fv  fd           row   done cnt
    vecs[0]  = '{1'b1, O1, 4'h0, 4'h0, 8'h00, 1'b1, 0, 1, 0, 24'h000000, 4'hF, 0, 16'd0};
    vecs[1]  = '{1'b1, O2, 4'hF, 4'h0, 8'h00, 1'b1, 0, 0, 0, 24'h000000, 4'hF, 0, 16'd0};
    vecs[2]  = '{1'b0, 0,  4'hF, 4'h0, 8'h00, 1'b1, 0, 0, 0, 24'h000000, 4'hF, 0, 16'd0};
    vecs[3]  = '{1'b0, 0,  4'hF, 4'hD, 8'h11, 1'b1, 0, 0, 0, 24'h000000, 4'h2, 0, 16'd0};
    vecs[4]  = '{1'b0, 0,  4'hF, 4'hD, 8'h11, 1'b1, 0, 0, 1, 24'h110000, 4'h3, 0, 16'd0};
    vecs[5]  = '{1'b0, 0,  4'hF, 4'hD, 8'h11, 1'b1, 0, 0, 1, 24'h110002, 4'h7, 0, 16'd0};
    vecs[6]  = '{1'b0, 0,  4'hF, 4'hD, 8'h11, 1'b1, 0, 0, 1, 24'h110003, 4'hF, 0, 16'd0};
    vecs[7]  = '{1'b0, 0,  4'hF, 4'h0, 8'h00, 1'b0, 0, 0, 1, 24'h110003, 4'hF, 0, 16'd0};
    vecs[8]  = '{1'b0, 0,  4'hF, 4'h6, 8'h22, 1'b0, 0, 0, 1, 24'h110003, 4'h9, 0, 16'd0};
    vecs[9]  = '{1'b0, 0,  4'hF, 4'h6, 8'h22, 1'b0, 0, 0, 1, 24'h110003, 4'h9, 0, 16'd0};
    vecs[10] = '{1'b0, 0,  4'hF, 4'h0, 8'h22, 1'b0, 0, 0, 1, 24'h110003, 4'h9, 0, 16'd0};
    vecs[11] = '{1'b0, 0,  4'hF, 4'h1, 8'h33, 1'b0, 0, 0, 1, 24'h110003, 4'h8, 0, 16'd0};
    vecs[12] = '{1'b0, 0,  4'hF, 4'h1, 8'h33, 1'b1, 0, 0, 1, 24'h330000, 4'h9, 0, 16'd0};
    vecs[13] = '{1'b0, 0,  4'hF, 4'h0, 8'h00, 1'b1, 0, 0, 1, 24'h220001, 4'hB, 0, 16'd0};
    vecs[14] = '{1'b0, 0,  4'hF, 4'h0, 8'h00, 1'b1, 0, 0, 1, 24'h220002, 4'hF, 0, 16'd0};
    vecs[15] = '{1'b0, 0,  4'hF, 4'h8, 8'h44, 1'b0, 0, 0, 1, 24'h220002, 4'h7, 0, 16'd0};
    vecs[16] = '{1'b0, 0,  4'hF, 4'h8, 8'h44, 1'b0, 0, 0, 1, 24'h220002, 4'h7, 0, 16'd0};
    vecs[17] = '{1'b0, 0,  4'hF, 4'h0, 8'h00, 1'b1, 0, 0, 1, 24'h440003, 4'hF, 0, 16'd0};
    vecs[18] = '{1'b0, 0,  4'hF, 4'h0, 8'h00, 1'b0, 0, 0, 1, 24'h440003, 4'hF, 0, 16'd0};
    vecs[19] = '{1'b0, 0,  4'hF, 4'h0, 8'h00, 1'b1, 0, 0, 0, 24'h440003, 4'hF, 0, 16'd0};
    vecs[20] = '{1'b0, 0,  4'h7, 4'h0, 8'h00, 1'b1, 0, 0, 0, 24'h440003, 4'hF, 0, 16'd0};
    vecs[21] = '{1'b0, 0,  4'hF, 4'h0, 8'h00, 1'b1, 1, 0, 0, 24'h440003, 4'hF, 1, 16'd1};
    vecs[22] = '{1'b0, 0,  4'hF, 4'h0, 8'h00, 1'b1, 1, 0, 0, 24'h440003, 4'hF, 0, 16'd1};

    drive(1'b0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    check("reset obj_ready", 32'(bus.obj_ready), 32'd1);
    check("reset next_task", 32'(bus.next_task), 32'd0);
    check("reset current_task", bus.current_task, 32'd0);
    check("reset fb_valid", 32'(bus.fb_valid), 32'd0);
    check("reset fb_data", 32'(bus.fb_data), 32'd0);
    check("reset output_written", 32'(bus.rast_output_written), 32'hF);
    check("reset obj_done", 32'(bus.obj_done), 32'd0);
    check("reset obj_count", 32'(bus.obj_count), 32'd0);
    check("reset state", 32'(bus.state_dbg), 32'd0);
    check("reset err_overrun", 32'(bus.err_overrun), 32'd0);

    drive(1'b1, O1, 4'h0, 4'h0, 8'h00, 1'b1);
    check("accept obj_ready", 32'(bus.obj_ready), 32'd1);

    for (int r = 0; r < 23; r++) begin
      drive(vecs[r].ov, vecs[r].oin, vecs[r].tc, vecs[r].rdw, vecs[r].tag, vecs[r].rdy);
      step();
      check($sformatf("row%0d obj_ready", r), 32'(bus.obj_ready), 32'(vecs[r].e_ordy));
      check($sformatf("row%0d next_task", r), 32'(bus.next_task), 32'(vecs[r].e_nt));
      check($sformatf("row%0d fb_valid", r), 32'(bus.fb_valid), 32'(vecs[r].e_fv));
      check($sformatf("row%0d fb_data", r), 32'(bus.fb_data), 32'(vecs[r].e_fd));
      check($sformatf("row%0d output_written", r), 32'(bus.rast_output_written), 32'(vecs[r].e_row));
      check($sformatf("row%0d obj_done", r), 32'(bus.obj_done), 32'(vecs[r].e_done));
      check($sformatf("row%0d obj_count", r), 32'(bus.obj_count), 32'(vecs[r].e_cnt));
      check($sformatf("row%0d current_task", r), bus.current_task, O1);
    end

    // Overrun: hold the output busy so slot 1 is still full at its second edge.
    drive(1'b0, 32'h0, 4'h0, 4'h1, 8'h55, 1'b0);
    step();
    check("ovr err before", 32'(bus.err_overrun), 32'd0);
    step();
    check("ovr first grant", 32'(bus.fb_data), 32'h550000);
    drive(1'b0, 32'h0, 4'h0, 4'h2, 8'h66, 1'b0);
    step();
    check("ovr slot1 full", 32'(bus.rast_output_written), 32'hD);
    drive(1'b0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    step();
    drive(1'b0, 32'h0, 4'h0, 4'h2, 8'h77, 1'b0);
    step();
    check("ovr err set", 32'(bus.err_overrun), 32'd1);
    check("ovr fb held", 32'(bus.fb_data), 32'h550000);
    check("ovr fb valid held", 32'(bus.fb_valid), 32'd1);
    drive(1'b0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b1);
    step();
    check("ovr kept pixel", 32'(bus.fb_data), 32'h660001);
    step();
    check("ovr drained", 32'(bus.fb_valid), 32'd0);
    check("ovr slots empty", 32'(bus.rast_output_written), 32'hF);

    // Reset in RUN with two slots full and the output register occupied.
    drive(1'b1, O2, 4'h0, 4'h0, 8'h00, 1'b0);
    step();
    check("obj2 next_task", 32'(bus.next_task), 32'd1);
    check("obj2 current_task", bus.current_task, O2);
    drive(1'b0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    step();
    step();
    step();
    check("obj2 in run", 32'(bus.state_dbg), 32'd3);
    drive(1'b0, 32'h0, 4'h0, 4'h1, 8'h88, 1'b0);
    step();
    step();
    check("obj2 fb_data", 32'(bus.fb_data), 32'h880000);
    drive(1'b0, 32'h0, 4'h0, 4'hC, 8'h99, 1'b0);
    step();
    check("pre-reset slots", 32'(bus.rast_output_written), 32'h3);
    check("pre-reset fb_valid", 32'(bus.fb_valid), 32'd1);
    #2;
    reset = 1'b1;
    step();
    check("mid reset fb_valid", 32'(bus.fb_valid), 32'd0);
    check("mid reset output_written", 32'(bus.rast_output_written), 32'hF);
    check("mid reset obj_ready", 32'(bus.obj_ready), 32'd1);
    check("mid reset obj_count", 32'(bus.obj_count), 32'd0);
    check("mid reset err_overrun", 32'(bus.err_overrun), 32'd0);
    check("mid reset current_task", bus.current_task, 32'd0);
    drive(1'b0, 32'h0, 4'hF, 4'h0, 8'h00, 1'b1);
    reset = 1'b0;
    step();
    check("post reset obj_done", 32'(bus.obj_done), 32'd0);
    check("post reset state", 32'(bus.state_dbg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
